axi_burst_ram: RTL and testbench

- AXI4 slave memory that sits directly downstream of the L2 cache's AXI master port (aw/w/b/ar/r channels).
- Serves INCR line-fill and write-back bursts from a single-port synchronous word RAM.
- Used in simulation and in FPGA builds without DDR, where it stands in for the DDR controller.
- Serves one transaction at a time: write and read bursts are serialised by a round-robin arbiter.

---
 rtl/axi_burst_ram_pkg.sv | 19 +
 rtl/axi_burst_ram_mem.sv | 31 +++
 rtl/axi_burst_ram.sv | 186 ++++++++++++++++++
 tb/tb_axi_burst_ram.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_ram_pkg.sv
// Shared definitions for the AXI4 burst RAM: burst types, response codes
// and the transaction FSM states.
package axi_burst_ram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2,
    RD_DATA = 2'd3
  } state_t;

endpackage

// File: rtl/axi_burst_ram_mem.sv
// Single-port synchronous word RAM with byte enables and a registered read.
// No reset: contents and the read register survive a bus reset.
module axi_burst_ram_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // The read register only moves on a read, so it doubles as the output hold.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < DATA_W/8; i++) begin
          if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/axi_burst_ram.sv
// AXI4 slave memory serving one burst at a time from a single-port RAM;
// write and read address channels share the port through a round-robin grant.
module axi_burst_ram
  import axi_burst_ram_pkg::*;
#(
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_ADDR_W = 16,
  parameter int unsigned ID_W       = 1
) (
  input  logic                clk,
  input  logic                rst,

  input  logic [ID_W-1:0]     axi_awid,
  input  logic [ADDR_W-1:0]   axi_awaddr,
  input  logic [7:0]          axi_awlen,
  input  logic [2:0]          axi_awsize,
  input  logic [1:0]          axi_awburst,
  input  logic                axi_awvalid,
  output logic                axi_awready,

  input  logic [DATA_W-1:0]   axi_wdata,
  input  logic [DATA_W/8-1:0] axi_wstrb,
  input  logic                axi_wlast,
  input  logic                axi_wvalid,
  output logic                axi_wready,

  output logic [ID_W-1:0]     axi_bid,
  output logic [1:0]          axi_bresp,
  output logic                axi_bvalid,
  input  logic                axi_bready,

  input  logic [ID_W-1:0]     axi_arid,
  input  logic [ADDR_W-1:0]   axi_araddr,
  input  logic [7:0]          axi_arlen,
  input  logic [2:0]          axi_arsize,
  input  logic [1:0]          axi_arburst,
  input  logic                axi_arvalid,
  output logic                axi_arready,

  output logic [ID_W-1:0]     axi_rid,
  output logic [DATA_W-1:0]   axi_rdata,
  output logic [1:0]          axi_rresp,
  output logic                axi_rlast,
  output logic                axi_rvalid,
  input  logic                axi_rready
);

  state_t                  state_q, state_d;
  logic                    prio_w_q;
  logic [ID_W-1:0]         id_q;
  logic [7:0]              len_q;
  logic [1:0]              burst_q;
  logic [MEM_ADDR_W-1:0]   addr_q;
  logic [8:0]              cnt_q;
  logic                    err_q;
  logic                    rvalid_q;
  logic                    rlast_q;

  logic                    idle, aw_hs, ar_hs, w_hs;
  logic                    wr_last, rd_more, rd_issue_burst, rd_issue;
  logic [MEM_ADDR_W-1:0]   aw_word, ar_word;
  logic                    ram_en, ram_we;
  logic [MEM_ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]       ram_q;

  logic                    unused_ok;
  assign unused_ok = ^{axi_awsize, axi_arsize, axi_awaddr, axi_araddr};

  // WRAP steps linearly like INCR; only the RAM index width bounds the address.
  function automatic logic [MEM_ADDR_W-1:0] next_addr(input logic [MEM_ADDR_W-1:0] a,
                                                      input logic [1:0]            burst);
    if (burst == BURST_INCR || burst == BURST_WRAP) return a + MEM_ADDR_W'(1);
    return a;
  endfunction

  assign idle    = (state_q == IDLE);
  assign aw_word = axi_awaddr[MEM_ADDR_W+1:2];
  assign ar_word = axi_araddr[MEM_ADDR_W+1:2];

  assign axi_awready = idle & rst & axi_awvalid & (~axi_arvalid | prio_w_q);
  assign axi_arready = idle & rst & axi_arvalid & (~axi_awvalid | ~prio_w_q);
  assign aw_hs       = axi_awready;
  assign ar_hs       = axi_arready;

  assign axi_wready  = (state_q == WR_DATA);
  assign w_hs        = axi_wready & axi_wvalid;
  assign wr_last     = (cnt_q == {1'b0, len_q});

  // The first read beat is issued in the ar handshake cycle itself, which
  // is what puts rvalid one cycle after the handshake.
  assign rd_more        = (cnt_q <= {1'b0, len_q});
  assign rd_issue_burst = (state_q == RD_DATA) & rd_more & (~rvalid_q | axi_rready);
  assign rd_issue       = ar_hs | rd_issue_burst;

  assign ram_en   = w_hs | rd_issue;
  assign ram_we   = w_hs;
  assign ram_addr = ar_hs ? ar_word : addr_q;

  axi_burst_ram_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_mem (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (axi_wstrb),
    .addr  (ram_addr),
    .wdata (axi_wdata),
    .rdata (ram_q)
  );

  assign axi_bvalid = (state_q == WR_RESP);
  assign axi_bid    = id_q;
  assign axi_bresp  = (axi_bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;

  assign axi_rvalid = rvalid_q;
  assign axi_rlast  = rlast_q;
  assign axi_rid    = id_q;
  assign axi_rresp  = RESP_OKAY;
  assign axi_rdata  = rvalid_q ? ram_q : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (aw_hs)      state_d = WR_DATA;
        else if (ar_hs) state_d = RD_DATA;
      end
      WR_DATA: if (w_hs && wr_last)                      state_d = WR_RESP;
      WR_RESP: if (axi_bready)                           state_d = IDLE;
      RD_DATA: if (rvalid_q && axi_rready && rlast_q)    state_d = IDLE;
      default:                                           state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_w_q <= 1'b1;
      id_q     <= '0;
      len_q    <= '0;
      burst_q  <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      if (aw_hs || ar_hs) prio_w_q <= ~prio_w_q;

      if (aw_hs) begin
        id_q    <= axi_awid;
        len_q   <= axi_awlen;
        burst_q <= axi_awburst;
        addr_q  <= aw_word;
        cnt_q   <= '0;
      end else if (ar_hs) begin
        id_q    <= axi_arid;
        len_q   <= axi_arlen;
        burst_q <= axi_arburst;
        addr_q  <= next_addr(ar_word, axi_arburst);
        cnt_q   <= 9'd1;
      end else if (w_hs || rd_issue_burst) begin
        addr_q  <= next_addr(addr_q, burst_q);
        cnt_q   <= cnt_q + 9'd1;
      end

      if (w_hs && (axi_wlast != wr_last))         err_q <= 1'b1;
      else if (state_q == WR_RESP && axi_bready)  err_q <= 1'b0;

      if (rd_issue) begin
        rvalid_q <= 1'b1;
        rlast_q  <= ar_hs ? (axi_arlen == 8'd0) : wr_last;
      end else if (axi_rready) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_ram.sv
// Randomised bench for axi_burst_ram with a transaction-level memory model
// and a per-cycle compare process.
module tb_axi_burst_ram;
  localparam int ADDR_W = 30, DATA_W = 32, MEM_ADDR_W = 16, ID_W = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [ID_W-1:0] axi_awid, axi_bid, axi_arid, axi_rid;
  logic [ADDR_W-1:0] axi_awaddr, axi_araddr;
  logic [7:0] axi_awlen, axi_arlen;
  logic [2:0] axi_awsize, axi_arsize;
  logic [1:0] axi_awburst, axi_arburst, axi_bresp, axi_rresp;
  logic axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
  logic axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rlast, axi_rvalid, axi_rready;
  logic [DATA_W-1:0] axi_wdata, axi_rdata;
  logic [DATA_W/8-1:0] axi_wstrb;

  axi_burst_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_ADDR_W(MEM_ADDR_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string what);
    checks++;
    failures++;
    $display("FAIL timeout_%s actual=no_handshake required=handshake at %0t", what, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_WD, M_WB, M_RD} ph_t;
  logic [31:0] mmem   [int unsigned];
  logic [3:0]  mvalid [int unsigned];
  ph_t ph = M_IDLE;
  bit m_prio = 1'b1, m_err = 1'b0, exp_aw, exp_ar;
  logic [ID_W-1:0] m_id;
  int m_len, m_cnt;
  logic [1:0] m_burst;
  int unsigned m_addr;
  logic [31:0] mask;

  function automatic int unsigned step(input int unsigned a, input logic [1:0] b);
    return (b == 2'b00) ? a : (a + 1) % 65536;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_awready", axi_awready, 0); chk("rst_arready", axi_arready, 0);
      chk("rst_wready", axi_wready, 0);   chk("rst_bvalid", axi_bvalid, 0);
      chk("rst_rvalid", axi_rvalid, 0);   chk("rst_rdata", axi_rdata, 0);
      chk("rst_rlast", axi_rlast, 0);     chk("rst_bresp", axi_bresp, 0);
      chk("rst_rresp", axi_rresp, 0);     chk("rst_bid", axi_bid, 0);
      chk("rst_rid", axi_rid, 0);
      ph = M_IDLE; m_prio = 1'b1; m_err = 1'b0;
    end else begin
      exp_aw = (ph == M_IDLE) && axi_awvalid && (!axi_arvalid || m_prio);
      exp_ar = (ph == M_IDLE) && axi_arvalid && (!axi_awvalid || !m_prio);
      chk("awready", axi_awready, exp_aw);
      chk("arready", axi_arready, exp_ar);
      chk("wready", axi_wready, ph == M_WD);
      chk("bvalid", axi_bvalid, ph == M_WB);
      chk("rvalid", axi_rvalid, ph == M_RD);
      case (ph)
        M_IDLE: begin
          if (exp_aw) begin
            ph = M_WD; m_id = axi_awid; m_len = axi_awlen; m_burst = axi_awburst;
            m_addr = axi_awaddr[17:2]; m_cnt = 0; m_err = 1'b0; m_prio = !m_prio;
          end else if (exp_ar) begin
            ph = M_RD; m_id = axi_arid; m_len = axi_arlen; m_burst = axi_arburst;
            m_addr = axi_araddr[17:2]; m_cnt = 0; m_prio = !m_prio;
          end
        end
        M_WD: if (axi_wvalid) begin
          if (!mmem.exists(m_addr)) begin mmem[m_addr] = '0; mvalid[m_addr] = '0; end
          for (int b = 0; b < 4; b++) if (axi_wstrb[b]) begin
            mmem[m_addr][b*8 +: 8] = axi_wdata[b*8 +: 8];
            mvalid[m_addr][b] = 1'b1;
          end
          if (axi_wlast != (m_cnt == m_len)) m_err = 1'b1;
          if (m_cnt == m_len) ph = M_WB;
          else begin m_cnt++; m_addr = step(m_addr, m_burst); end
        end
        M_WB: begin
          chk("bid", axi_bid, m_id);
          chk("bresp", axi_bresp, m_err ? 2'b10 : 2'b00);
          if (axi_bready) ph = M_IDLE;
        end
        M_RD: begin
          chk("rid", axi_rid, m_id);
          chk("rresp", axi_rresp, 0);
          chk("rlast", axi_rlast, m_cnt == m_len);
          mask = '0;
          if (mvalid.exists(m_addr))
            for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{mvalid[m_addr][b]}};
          if (mask != '0) chk("rdata", axi_rdata & mask, mmem[m_addr] & mask);
          if (axi_rready) begin
            if (m_cnt == m_len) ph = M_IDLE;
            else begin m_cnt++; m_addr = step(m_addr, m_burst); end
          end
        end
        default: ph = M_IDLE;
      endcase
    end
  end

  // ---------------- driver ----------------
  logic [31:0] wq_data[$], got[$], rec[16];
  logic [3:0]  wq_strb[$];
  logic        got_last[$];
  logic [1:0]  last_bresp;
  logic [ID_W-1:0] last_bid;
  bit g;

  task automatic set_aw(input logic [ID_W-1:0] id, input logic [29:0] a, input logic [7:0] len, input logic [1:0] bt);
    axi_awid = id; axi_awaddr = a; axi_awlen = len; axi_awburst = bt; axi_awsize = 3'd2; axi_awvalid = 1'b1;
  endtask

  task automatic set_ar(input logic [ID_W-1:0] id, input logic [29:0] a, input logic [7:0] len, input logic [1:0] bt);
    axi_arid = id; axi_araddr = a; axi_arlen = len; axi_arburst = bt; axi_arsize = 3'd2; axi_arvalid = 1'b1;
  endtask

  task automatic wait_grant(output bit got_w);
    bit seen = 1'b0;
    got_w = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (axi_awready || axi_arready) begin seen = 1'b1; got_w = axi_awready; end
    end
    if (!seen) begin timeout("grant"); axi_awvalid = 1'b0; axi_arvalid = 1'b0; return; end
    @(posedge clk); #1;
    if (got_w) axi_awvalid = 1'b0; else axi_arvalid = 1'b0;
  endtask

  task automatic w_phase(input int n, input int lastbeat);
    int i = 0, t = 0;
    while (i < n && t < 1000) begin
      @(posedge clk); #1;
      axi_wvalid = ($urandom_range(0, 3) != 0);
      axi_wdata = wq_data[i]; axi_wstrb = wq_strb[i]; axi_wlast = (i == lastbeat);
      @(negedge clk);
      if (axi_wvalid && axi_wready) i++;
      t++;
    end
    if (i < n) timeout("w");
    @(posedge clk); #1; axi_wvalid = 1'b0; axi_wlast = 1'b0;
  endtask

  task automatic b_phase();
    bit done = 1'b0;
    for (int t = 0; t < 500 && !done; t++) begin
      @(posedge clk); #1;
      axi_bready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (axi_bvalid && axi_bready) begin done = 1'b1; last_bid = axi_bid; last_bresp = axi_bresp; end
    end
    if (!done) timeout("b");
    @(posedge clk); #1; axi_bready = 1'b0;
  endtask

  // mode 0: random rready, 1: toggling 1,0,1,0, 2: always ready
  task automatic r_phase(input int n, input int mode);
    int k = 0, c = 0;
    got.delete(); got_last.delete();
    for (int t = 0; t < 2000 && k < n; t++) begin
      @(posedge clk); #1;
      axi_rready = (mode == 2) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : ($urandom_range(0, 3) != 0);
      c++;
      @(negedge clk);
      if (axi_rvalid && axi_rready) begin got.push_back(axi_rdata); got_last.push_back(axi_rlast); k++; end
    end
    if (k < n) timeout("r");
    @(posedge clk); #1; axi_rready = 1'b0;
  endtask

  task automatic wr_txn(input logic [ID_W-1:0] id, input logic [29:0] a, input int len, input logic [1:0] bt, input int lastbeat);
    set_aw(id, a, 8'(len), bt);
    wait_grant(g);
    chk("wr_grant", g, 1);
    w_phase(len + 1, (lastbeat < 0) ? len : lastbeat);
    b_phase();
  endtask

  task automatic rd_txn(input logic [ID_W-1:0] id, input logic [29:0] a, input int len, input logic [1:0] bt, input int mode);
    set_ar(id, a, 8'(len), bt);
    wait_grant(g);
    chk("rd_grant", g, 0);
    chk("rd_first_beat_latency", axi_rvalid, 1);
    r_phase(len + 1, mode);
  endtask

  task automatic fill1(input logic [31:0] d, input logic [3:0] s);
    wq_data.delete(); wq_strb.delete(); wq_data.push_back(d); wq_strb.push_back(s);
  endtask

  initial begin
    int k, lb;
    int unsigned word;
    logic [29:0] a;
    rst = 1'b0;
    axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awsize = '0; axi_awburst = '0; axi_awvalid = 1'b0;
    axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0; axi_bready = 1'b0;
    axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arsize = '0; axi_arburst = '0; axi_arvalid = 1'b0;
    axi_rready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // contention right after reset: write first, then read
    wq_data = '{32'h1234_5678, 32'h9ABC_DEF0}; wq_strb = '{4'hF, 4'hF};
    set_aw(1, 30'h600, 8'd1, 2'b01); set_ar(0, 30'h600, 8'd0, 2'b01);
    wait_grant(g); chk("cont1_first_write", g, 1);
    w_phase(2, 1); b_phase();
    wait_grant(g); chk("cont1_second_read", g, 0);
    r_phase(1, 2); chk("cont1_rdata", got[0], 32'h1234_5678);
    fill1(32'h0BAD_F00D, 4'hF); wr_txn(0, 30'h640, 0, 2'b01, -1);
    fill1(32'h5555_AAAA, 4'hF);
    set_aw(0, 30'h700, 8'd0, 2'b01); set_ar(1, 30'h604, 8'd0, 2'b01);
    wait_grant(g); chk("cont2_first_read", g, 0);
    r_phase(1, 2); chk("cont2_rdata", got[0], 32'h9ABC_DEF0);
    wait_grant(g); chk("cont2_second_write", g, 1);
    w_phase(1, 0); b_phase();

    // single beat
    fill1(32'hDEAD_BEEF, 4'hF); wr_txn(1, 30'h100, 0, 2'b01, -1);
    chk("single_bresp", last_bresp, 2'b00); chk("single_bid", last_bid, 1);
    rd_txn(0, 30'h100, 0, 2'b01, 2);
    chk("single_rdata", got[0], 32'hDEAD_BEEF); chk("single_rlast", got_last[0], 1);

    // 16-word line with toggling rready
    wq_data.delete(); wq_strb.delete();
    for (int i = 0; i < 16; i++) begin wq_data.push_back(32'(i)); wq_strb.push_back(4'hF); end
    wr_txn(0, 30'h2000, 15, 2'b01, -1);
    rd_txn(1, 30'h2000, 15, 2'b01, 1);
    for (int i = 0; i < 16; i++) begin
      chk("line_rdata", got[i], 32'(i)); chk("line_rlast", got_last[i], i == 15);
    end

    // byte strobes
    fill1(32'hFFFF_FFFF, 4'hF); wr_txn(0, 30'h300, 0, 2'b01, -1);
    fill1(32'h0000_0012, 4'h1); wr_txn(0, 30'h300, 0, 2'b01, -1);
    rd_txn(0, 30'h300, 0, 2'b01, 0); chk("strobe_rdata", got[0], 32'hFFFF_FF12);

    // early wlast -> SLVERR; wrap at top of RAM
    wq_data = '{32'h1, 32'h2, 32'h3, 32'h4}; wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
    wr_txn(1, 30'h800, 3, 2'b01, 1); chk("early_wlast_bresp", last_bresp, 2'b10);
    rd_txn(0, 30'h80C, 0, 2'b01, 2); chk("early_wlast_all_beats", got[0], 32'h4);
    wq_data = '{32'hA5A5_0001, 32'hA5A5_0002}; wq_strb = '{4'hF, 4'hF};
    wr_txn(1, 30'h3FFFC, 1, 2'b01, -1); chk("wrap_bresp", last_bresp, 2'b00);
    rd_txn(0, 30'h0, 0, 2'b01, 2); chk("wrap_word0", got[0], 32'hA5A5_0002);
    rd_txn(0, 30'h3FFFC, 1, 2'b01, 0);
    chk("wrap_rd0", got[0], 32'hA5A5_0001); chk("wrap_rd1", got[1], 32'hA5A5_0002);

    // reset during beat 5 of a 16-beat read
    wq_data.delete(); wq_strb.delete();
    for (int i = 0; i < 16; i++) begin rec[i] = $urandom; wq_data.push_back(rec[i]); wq_strb.push_back(4'hF); end
    wr_txn(0, 30'h4000, 15, 2'b01, -1);
    set_ar(0, 30'h4000, 8'd15, 2'b01); wait_grant(g);
    axi_rready = 1'b1; k = 0;
    for (int t = 0; t < 100 && k < 4; t++) begin @(negedge clk); if (axi_rvalid && axi_rready) k++; end
    if (k < 4) timeout("rst_beats");
    @(posedge clk); #2;
    set_ar(1, 30'h4000, 8'd0, 2'b01);
    rst = 1'b0; #1;
    chk("rst_mid_rvalid", axi_rvalid, 0); chk("rst_mid_arready", axi_arready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; axi_arvalid = 1'b0; axi_rready = 1'b0;
    rd_txn(1, 30'h4000, 15, 2'b01, 0);
    for (int i = 0; i < 16; i++) chk("rst_preserved", got[i], rec[i]);

    // randomised traffic
    for (int t = 0; t < 40; t++) begin
      word = ($urandom_range(0, 7) == 0) ? (65536 - $urandom_range(1, 6)) : $urandom_range(0, 63);
      a = {12'($urandom), 16'(word), 2'($urandom)};
      k = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        wq_data.delete(); wq_strb.delete();
        for (int i = 0; i <= k; i++) begin
          wq_data.push_back($urandom);
          wq_strb.push_back(($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom));
        end
        lb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, k + 1)) : -1;
        wr_txn(1'($urandom), a, k, 2'($urandom_range(0, 2)), lb);
      end else begin
        rd_txn(1'($urandom), a, k, 2'($urandom_range(0, 2)), 0);
      end
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=running required=finished at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
